// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the scoreboarded register file: data width,
// register count, read-port count and the address-width derivation.
package reg_file_sb_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;

   // Address width for a register file of nregs entries (never below 1 bit).
   function automatic int addr_width(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/reg_file_sb_rdport.sv
// One combinational read port: register mux, same-cycle write forwarding
// and the busy lookup. A forwarded write hides the busy bit because the
// operand it delivers is the value the pending producer is writing now.
module reg_file_sb_rdport
   import reg_file_sb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int BYPASS = 1,
   parameter int AW     = addr_width(NREGS_DEF)
) (
   input  logic                   rst,
   input  logic [NREGS*XLEN-1:0]  reg_flat,
   input  logic [NREGS-1:0]       busy,
   input  logic [AW-1:0]          raddr,
   input  logic                   write0,
   input  logic [AW-1:0]          waddr0,
   input  logic [XLEN-1:0]        wdata0,
   input  logic                   write1,
   input  logic [AW-1:0]          waddr1,
   input  logic [XLEN-1:0]        wdata1,
   output logic [XLEN-1:0]        rdata,
   output logic                   rbusy
);

   logic hit0;
   logic hit1;

   // Forwarding hits never apply to register 0 or while reset is held.
   always_comb begin
      hit0 = (BYPASS != 0) && !rst && write0 && (waddr0 == raddr) && (raddr != '0);
      hit1 = (BYPASS != 0) && !rst && write1 && (waddr1 == raddr) && (raddr != '0);
   end

   // Read data: port 1 forwarding beats port 0, both beat the stored value.
   always_comb begin
      rdata = reg_flat[int'(raddr)*XLEN +: XLEN];
      if (hit1)
         rdata = wdata1;
      else if (hit0)
         rdata = wdata0;
      if (rst)
         rdata = '0;
   end

   // Busy flag for this operand, masked by an active forwarding write.
   always_comb begin
      rbusy = busy[raddr] && !hit0 && !hit1 && !rst;
   end

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, NRD-read register file with a per-register busy scoreboard.
// Register 0 is hard-wired to zero and never becomes busy. PENDING is the
// registered population count of busy bits.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = NRD_DEF,
   parameter int BYPASS = 1,
   localparam int AW    = addr_width(NREGS)
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                WRITE0,
   input  logic                WRITE1,
   input  logic [AW-1:0]       INADDRESS0,
   input  logic [AW-1:0]       INADDRESS1,
   input  logic [XLEN-1:0]     IN0,
   input  logic [XLEN-1:0]     IN1,
   input  logic [NRD*AW-1:0]   OUTADDRESS,
   output logic [NRD*XLEN-1:0] OUT,
   input  logic                ISSUE,
   input  logic [AW-1:0]       ISSUEADDRESS,
   output logic [NRD-1:0]      BUSY,
   output logic [AW:0]         PENDING
);

   logic [XLEN-1:0]       regs [1:NREGS-1];
   logic [NREGS*XLEN-1:0] reg_flat;
   logic [NREGS-1:0]      busy;
   logic [NREGS-1:0]      busy_next;
   logic [AW:0]           count_next;
   logic [AW:0]           pending;

   // Register storage; port 1 is applied last so it wins a same-address clash.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (WRITE1 && (INADDRESS1 == AW'(i)))
               regs[i] <= IN1;
            else if (WRITE0 && (INADDRESS0 == AW'(i)))
               regs[i] <= IN0;
         end
      end
   end

   // Flatten storage for the read ports, with register 0 tied to zero.
   always_comb begin
      reg_flat = '0;
      for (int i = 1; i < NREGS; i++) reg_flat[i*XLEN +: XLEN] = regs[i];
   end

   // Next busy vector: writeback clears, issue sets, and issue is applied
   // last so a new producer keeps ownership over a retiring one.
   always_comb begin
      busy_next = busy;
      for (int i = 1; i < NREGS; i++) begin
         if ((WRITE0 && (INADDRESS0 == AW'(i))) || (WRITE1 && (INADDRESS1 == AW'(i))))
            busy_next[i] = 1'b0;
         if (ISSUE && (ISSUEADDRESS == AW'(i)))
            busy_next[i] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Population count of the next busy vector, registered alongside it.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < NREGS; i++) count_next = count_next + (AW+1)'(busy_next[i]);
   end

   // Scoreboard state and its pending count.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         busy    <= '0;
         pending <= '0;
      end else begin
         busy    <= busy_next;
         pending <= count_next;
      end
   end

   assign PENDING = pending;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      reg_file_sb_rdport #(
         .XLEN   (XLEN),
         .NREGS  (NREGS),
         .BYPASS (BYPASS),
         .AW     (AW)
      ) u_rdport (
         .rst    (RESET),
         .reg_flat (reg_flat),
         .busy   (busy),
         .raddr  (OUTADDRESS[k*AW +: AW]),
         .write0 (WRITE0),
         .waddr0 (INADDRESS0),
         .wdata0 (IN0),
         .write1 (WRITE1),
         .waddr1 (INADDRESS1),
         .wdata1 (IN1),
         .rdata  (OUT[k*XLEN +: XLEN]),
         .rbusy  (BUSY[k])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding instance and a non-forwarding
// instance share all inputs. Directed table, reset and fill sequences,
// then random traffic against an array-based register/scoreboard model.
module tb_reg_file_sb;
   import reg_file_sb_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = addr_width(NREGS);

   logic                clk;
   logic                rst;
   logic                write0, write1;
   logic [AW-1:0]       in_addr0, in_addr1;
   logic [XLEN-1:0]     in0, in1;
   logic [NRD*AW-1:0]   out_addr;
   logic                issue;
   logic [AW-1:0]       issue_addr;
   logic [NRD*XLEN-1:0] out_bp, out_nb;
   logic [NRD-1:0]      busy_bp, busy_nb;
   logic [AW:0]         pend_bp, pend_nb;

   int n_pass  = 0;
   int n_total = 0;

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_bp (
      .CLOCK(clk), .RESET(rst), .WRITE0(write0), .WRITE1(write1),
      .INADDRESS0(in_addr0), .INADDRESS1(in_addr1), .IN0(in0), .IN1(in1),
      .OUTADDRESS(out_addr), .OUT(out_bp), .ISSUE(issue), .ISSUEADDRESS(issue_addr),
      .BUSY(busy_bp), .PENDING(pend_bp)
   );

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_nb (
      .CLOCK(clk), .RESET(rst), .WRITE0(write0), .WRITE1(write1),
      .INADDRESS0(in_addr0), .INADDRESS1(in_addr1), .IN0(in0), .IN1(in1),
      .OUTADDRESS(out_addr), .OUT(out_nb), .ISSUE(issue), .ISSUEADDRESS(issue_addr),
      .BUSY(busy_nb), .PENDING(pend_nb)
   );

   // Clock: 10 ns period, rising edge active.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];

   function automatic void m_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   // Apply one rising edge with the currently driven inputs.
   function automatic void m_step();
      if (rst) begin
         m_reset();
         return;
      end
      if (write0 && in_addr0 != 0) m_regs[in_addr0] = in0;
      if (write1 && in_addr1 != 0) m_regs[in_addr1] = in1;
      if (write0) m_busy[in_addr0] = 1'b0;
      if (write1) m_busy[in_addr1] = 1'b0;
      if (issue && issue_addr != 0) m_busy[issue_addr] = 1'b1;
   endfunction

   function automatic int m_pending();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic bit m_fwd(int a, bit bp, bit port);
      if (!bp || rst || a == 0) return 1'b0;
      if (port) return write1 && int'(in_addr1) == a;
      return write0 && int'(in_addr0) == a;
   endfunction

   function automatic logic [XLEN-1:0] m_read(int a, bit bp);
      if (rst) return '0;
      if (m_fwd(a, bp, 1'b1)) return in1;
      if (m_fwd(a, bp, 1'b0)) return in0;
      return m_regs[a];
   endfunction

   function automatic bit m_busy_rd(int a, bit bp);
      if (rst) return 1'b0;
      return m_busy[a] && !m_fwd(a, bp, 1'b0) && !m_fwd(a, bp, 1'b1);
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      write0 = 0; write1 = 0; in_addr0 = '0; in_addr1 = '0; in0 = '0; in1 = '0;
      issue = 0; issue_addr = '0;
   endtask

   task automatic set_read(input int a0, input int a1);
      out_addr = {AW'(a1), AW'(a0)};
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic w0; logic [AW-1:0] a0; logic [XLEN-1:0] d0;
      logic w1; logic [AW-1:0] a1; logic [XLEN-1:0] d1;
      logic iss; logic [AW-1:0] ia;
      int r0, r1;
      logic [XLEN-1:0] eo0, eo1, en0, en1;
      logic [1:0] eb, ebn;
      logic [AW:0] ep;
   } vec_t;

   function automatic vec_t mk(int w0, int a0, int d0, int w1, int a1, int d1, int iss, int ia,
                               int r0, int r1, int eo0, int eo1, int en0, int en1,
                               int eb, int ebn, int ep);
      vec_t v;
      v.w0 = w0[0]; v.a0 = AW'(a0); v.d0 = XLEN'(d0);
      v.w1 = w1[0]; v.a1 = AW'(a1); v.d1 = XLEN'(d1);
      v.iss = iss[0]; v.ia = AW'(ia);
      v.r0 = r0; v.r1 = r1;
      v.eo0 = XLEN'(eo0); v.eo1 = XLEN'(eo1); v.en0 = XLEN'(en0); v.en1 = XLEN'(en1);
      v.eb = 2'(eb); v.ebn = 2'(ebn); v.ep = (AW+1)'(ep);
      return v;
   endfunction

   vec_t vecs [10];

   initial begin
      //               w0 a0 d0  w1 a1 d1 is ia r0 r1 eo0 eo1 en0 en1 eb ebn ep
      vecs[0] = mk(1, 2, 95, 0, 0, 0,  0, 0, 2, 0, 95, 0,  0,  0,  0, 0, 0);
      vecs[1] = mk(0, 0, 0,  0, 0, 0,  0, 0, 2, 2, 95, 95, 95, 95, 0, 0, 0);
      vecs[2] = mk(1, 4, 6,  1, 4, 15, 0, 0, 4, 4, 15, 15, 0,  0,  0, 0, 0);
      vecs[3] = mk(1, 0, 50, 0, 0, 0,  0, 0, 4, 0, 15, 0,  15, 0,  0, 0, 0);
      vecs[4] = mk(0, 0, 0,  0, 0, 0,  1, 1, 1, 4, 0,  15, 0,  15, 0, 0, 1);
      vecs[5] = mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0,  0,  0,  0,  3, 3, 1);
      vecs[6] = mk(0, 0, 0,  1, 1, 28, 0, 0, 1, 4, 28, 15, 0,  15, 0, 1, 0);
      vecs[7] = mk(0, 0, 0,  0, 0, 0,  0, 0, 1, 4, 28, 15, 28, 15, 0, 0, 0);
      vecs[8] = mk(1, 3, 9,  0, 0, 0,  1, 3, 3, 1, 9,  28, 0,  28, 0, 0, 1);
      vecs[9] = mk(0, 0, 0,  0, 0, 0,  0, 0, 3, 1, 9,  28, 9,  28, 1, 1, 1);

      // Reset block
      rst = 1'b1;
      set_idle();
      set_read(5, 0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_pending", 64'(pend_bp), 64'd0);
      check("reset_out", 64'(out_bp), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         write0 = vecs[i].w0; in_addr0 = vecs[i].a0; in0 = vecs[i].d0;
         write1 = vecs[i].w1; in_addr1 = vecs[i].a1; in1 = vecs[i].d1;
         issue = vecs[i].iss; issue_addr = vecs[i].ia;
         set_read(vecs[i].r0, vecs[i].r1);
         #1;
         check($sformatf("tbl%0d_out0", i), 64'(out_bp[XLEN-1:0]), 64'(vecs[i].eo0));
         check($sformatf("tbl%0d_out1", i), 64'(out_bp[2*XLEN-1:XLEN]), 64'(vecs[i].eo1));
         check($sformatf("tbl%0d_nb_out0", i), 64'(out_nb[XLEN-1:0]), 64'(vecs[i].en0));
         check($sformatf("tbl%0d_nb_out1", i), 64'(out_nb[2*XLEN-1:XLEN]), 64'(vecs[i].en1));
         check($sformatf("tbl%0d_busy", i), 64'(busy_bp), 64'(vecs[i].eb));
         check($sformatf("tbl%0d_nb_busy", i), 64'(busy_nb), 64'(vecs[i].ebn));
         @(posedge clk);
         m_step();
         #1;
         check($sformatf("tbl%0d_pending", i), 64'(pend_bp), 64'(vecs[i].ep));
         check($sformatf("tbl%0d_nb_pending", i), 64'(pend_nb), 64'(vecs[i].ep));
      end

      // Asynchronous reset mid-cycle after x5=7 (x3 still busy from the table)
      @(negedge clk);
      set_idle();
      write0 = 1; in_addr0 = AW'(5); in0 = 7;
      @(posedge clk);
      m_step();
      #1;
      set_idle();
      set_read(5, 3);
      #1;
      check("pre_reset_x5", 64'(out_bp[XLEN-1:0]), 64'd7);
      check("pre_reset_pending", 64'(pend_bp), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_x5", 64'(out_bp[XLEN-1:0]), 64'd0);
      check("async_reset_pending", 64'(pend_bp), 64'd0);
      check("async_reset_nb_pending", 64'(pend_nb), 64'd0);
      m_reset();
      @(negedge clk);
      write0 = 1; in_addr0 = AW'(6); in0 = 33;
      issue = 1; issue_addr = AW'(7);
      set_read(6, 7);
      #1;
      check("reset_bypass_masked", 64'(out_bp), 64'd0);
      check("reset_busy", 64'(busy_bp), 64'd0);
      @(posedge clk);
      #1;
      check("reset_issue_ignored", 64'(pend_bp), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      set_read(6, 5);
      #1;
      check("reset_write_ignored", 64'(out_bp), 64'd0);

      // Fill the scoreboard with x1..x31, then issue x0
      for (int a = 1; a < NREGS; a++) begin
         @(negedge clk);
         set_idle();
         issue = 1; issue_addr = AW'(a);
         @(posedge clk);
         m_step();
      end
      #1;
      check("fill_pending", 64'(pend_bp), 64'd31);
      @(negedge clk);
      set_idle();
      issue = 1; issue_addr = '0;
      set_read(0, 31);
      #1;
      check("fill_busy_x0_x31", 64'(busy_bp), 64'b10);
      @(posedge clk);
      m_step();
      #1;
      check("issue_x0_pending", 64'(pend_bp), 64'd31);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         write0 = 1'($urandom_range(0, 1));
         in_addr0 = AW'($urandom_range(0, NREGS - 1));
         in0 = $urandom;
         write1 = 1'($urandom_range(0, 1));
         in_addr1 = ($urandom_range(0, 3) == 0) ? in_addr0 : AW'($urandom_range(0, NREGS - 1));
         in1 = $urandom;
         issue = ($urandom_range(0, 2) == 0);
         issue_addr = ($urandom_range(0, 3) == 0) ? in_addr1 : AW'($urandom_range(0, NREGS - 1));
         set_read(($urandom_range(0, 2) == 0) ? int'(in_addr0) : $urandom_range(0, NREGS - 1),
                  ($urandom_range(0, 2) == 0) ? int'(in_addr1) : $urandom_range(0, NREGS - 1));
         #1;
         for (int k = 0; k < NRD; k++) begin
            int a;
            a = int'(out_addr[k*AW +: AW]);
            check($sformatf("rnd%0d_out%0d", n, k), 64'(out_bp[k*XLEN +: XLEN]), 64'(m_read(a, 1'b1)));
            check($sformatf("rnd%0d_nb_out%0d", n, k), 64'(out_nb[k*XLEN +: XLEN]), 64'(m_read(a, 1'b0)));
            check($sformatf("rnd%0d_busy%0d", n, k), 64'(busy_bp[k]), 64'(m_busy_rd(a, 1'b1)));
            check($sformatf("rnd%0d_nb_busy%0d", n, k), 64'(busy_nb[k]), 64'(m_busy_rd(a, 1'b0)));
         end
         @(posedge clk);
         m_step();
         #1;
         check($sformatf("rnd%0d_pending", n), 64'(pend_bp), 64'(m_pending()));
         check($sformatf("rnd%0d_nb_pending", n), 64'(pend_nb), 64'(m_pending()));
      end

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
